// File: rtl/axis_ask_uart_rx.sv
// ASK-line UART receiver: decodes 2-bit comparator levels into 8N1 frames
// and delivers received bytes through a first-word fall-through FIFO on AXI-Stream.
`timescale 1ns/1ps
module axis_ask_uart_rx #(
   parameter int RX_SIZE   = 4,
   parameter int clkdiv_rx = 100
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] ask_rx,
   output logic [7:0] o_tdata,
   output logic       o_tvalid,
   input  logic       o_tready,
   output logic       o_frame_err,
   output logic       o_overflow,
   output logic       o_carrier
);

   localparam int CW    = $clog2(clkdiv_rx);
   localparam int DEPTH = 2 ** RX_SIZE;
   localparam logic [CW-1:0]      HALF_M1 = CW'(clkdiv_rx / 2 - 1);
   localparam logic [CW-1:0]      FULL_M1 = CW'(clkdiv_rx - 1);
   localparam logic [RX_SIZE:0]   DEPTH_C = (RX_SIZE + 1)'(DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_WAIT1 = 3'd4
   } state_t;

   logic [1:0]         r_sync1;
   logic [1:0]         r_sync2;
   logic [2:0]         r_hist;
   logic               r_carrier;
   state_t             r_state;
   logic               r_armed;
   logic [CW-1:0]      r_cnt;
   logic [2:0]         r_bitcnt;
   logic [7:0]         r_shift;
   logic               r_frame_err;
   logic               r_overflow;
   logic [7:0]         r_mem [DEPTH];
   logic [RX_SIZE-1:0] r_wptr;
   logic [RX_SIZE-1:0] r_rptr;
   logic [RX_SIZE:0]   r_count;

   logic w_carrier;
   logic w_bit;
   logic w_maj;
   logic w_push;
   logic w_pop;
   logic w_push_ok;

   // 11 = mark, 01 = space; bit 0 low means no carrier
   assign w_carrier = r_sync2[0];
   assign w_bit     = r_sync2[1] & r_sync2[0];
   assign w_maj     = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);

   assign w_push    = (r_state == ST_STOP) && w_carrier && (r_cnt == '0) && w_maj;
   assign w_pop     = o_tvalid & o_tready;
   assign w_push_ok = w_push && ((r_count != DEPTH_C) || w_pop);

   assign o_tvalid    = (r_count != '0);
   assign o_tdata     = o_tvalid ? r_mem[r_rptr] : 8'h00;
   assign o_frame_err = r_frame_err;
   assign o_overflow  = r_overflow;
   assign o_carrier   = r_carrier;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1   <= 2'b00;
         r_sync2   <= 2'b00;
         r_hist    <= 3'b000;
         r_carrier <= 1'b0;
      end else begin
         r_sync1   <= ask_rx;
         r_sync2   <= r_sync1;
         r_hist    <= {r_hist[1:0], w_bit};
         r_carrier <= w_carrier;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_armed     <= 1'b0;
         r_cnt       <= '0;
         r_bitcnt    <= 3'd0;
         r_shift     <= 8'h00;
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;
         if (w_carrier && w_bit) begin
            r_armed <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (!w_carrier) begin
                  r_armed <= 1'b0;
               end else if (r_armed && !w_bit) begin
                  r_state  <= ST_START;
                  r_cnt    <= HALF_M1;
                  r_bitcnt <= 3'd0;
               end
            end
            ST_START, ST_DATA, ST_STOP: begin
               if (!w_carrier) begin
                  r_frame_err <= 1'b1;
                  r_armed     <= 1'b0;
                  r_state     <= ST_IDLE;
               end else if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CW'(1);
               end else begin
                  r_cnt <= FULL_M1;
                  if (r_state == ST_START) begin
                     // a start bit that reads back as 1 is a line glitch, not an error
                     r_state <= w_maj ? ST_IDLE : ST_DATA;
                  end else if (r_state == ST_DATA) begin
                     r_shift  <= {w_maj, r_shift[7:1]};
                     r_bitcnt <= r_bitcnt + 3'd1;
                     if (r_bitcnt == 3'd7) begin
                        r_state <= ST_STOP;
                     end
                  end else if (w_maj) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_armed     <= 1'b0;
                     r_state     <= ST_WAIT1;
                  end
               end
            end
            ST_WAIT1: begin
               if (!w_carrier) begin
                  r_armed <= 1'b0;
               end else if (w_bit) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_armed <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wptr] <= r_shift;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= w_push && !w_push_ok;
         if (w_push_ok) begin
            r_wptr <= r_wptr + RX_SIZE'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + RX_SIZE'(1);
         end
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + (RX_SIZE + 1)'(1);
            2'b01:   r_count <= r_count - (RX_SIZE + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_ask_uart_rx.sv
// Scoreboard bench for axis_ask_uart_rx: expected bytes are queued as frames are
// driven and compared as beats leave the AXI-Stream port.
`timescale 1ns/1ps
module tb_axis_ask_uart_rx;

   localparam int DIV     = 100;
   localparam int RX_SIZE = 4;
   localparam int FRAME   = 10 * DIV;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] ask_rx = 2'b11;
   logic [7:0] o_tdata;
   logic       o_tvalid;
   logic       o_tready = 1'b0;
   logic       o_frame_err;
   logic       o_overflow;
   logic       o_carrier;

   int vectors = 0;
   int miscompares = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   int beat_cnt = 0;
   logic [7:0] exp_q [$];

   axis_ask_uart_rx #(.RX_SIZE(RX_SIZE), .clkdiv_rx(DIV)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ask_rx      (ask_rx),
      .o_tdata     (o_tdata),
      .o_tvalid    (o_tvalid),
      .o_tready    (o_tready),
      .o_frame_err (o_frame_err),
      .o_overflow  (o_overflow),
      .o_carrier   (o_carrier)
   );

   always #5 clk = ~clk;

   // inputs change 2 ns after posedge, so negedge sees a stable handshake
   always @(negedge clk) begin
      if (rst_n) begin
         if (o_frame_err) fe_cnt++;
         if (o_overflow)  ov_cnt++;
         if (o_tvalid && o_tready) begin
            logic [7:0] e;
            beat_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_beat: got %02h, none expected", o_tdata);
            end else begin
               e = exp_q.pop_front();
               if (o_tdata !== e) begin
                  miscompares++;
                  $display("FAIL beat_data: got %02h, expected %02h", o_tdata, e);
               end else begin
                  $display("beat %0d data=%02h ok", beat_cnt, o_tdata);
               end
            end
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic [1:0] s, input int n);
      ask_rx = s;
      cyc(n);
   endtask

   // One 8N1 frame, cycle by cycle; loss_bit forces 00 for that bit slot,
   // glitch forces a single 11 cycle, ncyc allows truncating the frame.
   task automatic send_frame(input logic [7:0] b, input logic [1:0] stop_sym,
                             input int glitch, input int loss_bit, input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         int bi;
         logic [1:0] s;
         bi = c / DIV;
         if (bi == 0)      s = 2'b01;
         else if (bi <= 8) s = b[bi-1] ? 2'b11 : 2'b01;
         else              s = stop_sym;
         if (bi == loss_bit) s = 2'b00;
         if (c == glitch)    s = 2'b11;
         ask_rx = s;
         @(posedge clk);
         #2;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ask_rx = 2'b11;
      cyc(3);
      vectors++; if (o_tvalid !== 1'b0)    begin miscompares++; $display("FAIL reset_tvalid: got %b, expected 0", o_tvalid); end
      vectors++; if (o_tdata !== 8'h00)    begin miscompares++; $display("FAIL reset_tdata: got %02h, expected 00", o_tdata); end
      vectors++; if (o_frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b, expected 0", o_frame_err); end
      vectors++; if (o_overflow !== 1'b0)  begin miscompares++; $display("FAIL reset_overflow: got %b, expected 0", o_overflow); end
      vectors++; if (o_carrier !== 1'b0)   begin miscompares++; $display("FAIL reset_carrier: got %b, expected 0", o_carrier); end
      rst_n = 1'b1;
      cyc(10);
      vectors++; if (o_carrier !== 1'b1)   begin miscompares++; $display("FAIL carrier_after_reset: got %b, expected 1", o_carrier); end
      vectors++; if (o_tvalid !== 1'b0)    begin miscompares++; $display("FAIL tvalid_after_reset: got %b, expected 0", o_tvalid); end
   endtask

   task automatic test_single();
      int fe0, ov0, b0;
      fe0 = fe_cnt; ov0 = ov_cnt; b0 = beat_cnt;
      o_tready = 1'b1;
      exp_q.push_back(8'hA5);
      fork
         send_frame(8'hA5, 2'b11, -1, -1, FRAME);
         begin
            repeat (952) @(posedge clk);
            @(negedge clk);
            vectors++; if (o_tvalid !== 1'b0) begin miscompares++; $display("FAIL tvalid_before_push: got %b, expected 0", o_tvalid); end
            @(negedge clk);
            vectors++; if (o_tvalid !== 1'b1) begin miscompares++; $display("FAIL tvalid_at_push: got %b, expected 1", o_tvalid); end
         end
      join
      drive(2'b11, 50);
      vectors++; if (beat_cnt - b0 !== 1) begin miscompares++; $display("FAIL single_beats: got %0d, expected 1", beat_cnt - b0); end
      vectors++; if (fe_cnt - fe0 !== 0)  begin miscompares++; $display("FAIL single_frame_err: got %0d, expected 0", fe_cnt - fe0); end
      vectors++; if (ov_cnt - ov0 !== 0)  begin miscompares++; $display("FAIL single_overflow: got %0d, expected 0", ov_cnt - ov0); end
   endtask

   task automatic test_back_to_back();
      int ov0, b0;
      logic [7:0] v;
      ov0 = ov_cnt; b0 = beat_cnt;
      o_tready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         v = 8'(i);
         if (i < 16) exp_q.push_back(v);
         send_frame(v, 2'b11, -1, -1, FRAME);
      end
      drive(2'b11, 20);
      vectors++; if (ov_cnt - ov0 !== 4) begin miscompares++; $display("FAIL overflow_pulses: got %0d, expected 4", ov_cnt - ov0); end
      vectors++; if (o_tvalid !== 1'b1)  begin miscompares++; $display("FAIL full_tvalid: got %b, expected 1", o_tvalid); end
      vectors++; if (o_tdata !== 8'h00)  begin miscompares++; $display("FAIL stalled_head: got %02h, expected 00", o_tdata); end
      vectors++; if (beat_cnt - b0 !== 0) begin miscompares++; $display("FAIL stalled_beats: got %0d, expected 0", beat_cnt - b0); end
      o_tready = 1'b1;
      drive(2'b11, 40);
      vectors++; if (beat_cnt - b0 !== 16)  begin miscompares++; $display("FAIL drain_beats: got %0d, expected 16", beat_cnt - b0); end
      vectors++; if (exp_q.size() !== 0)    begin miscompares++; $display("FAIL drain_left: got %0d, expected 0", exp_q.size()); end
      vectors++; if (o_tvalid !== 1'b0)     begin miscompares++; $display("FAIL drain_tvalid: got %b, expected 0", o_tvalid); end
   endtask

   task automatic test_frame_err();
      int fe0, ov0, b0;
      fe0 = fe_cnt; ov0 = ov_cnt; b0 = beat_cnt;
      o_tready = 1'b1;
      send_frame(8'h3C, 2'b01, -1, -1, FRAME);
      drive(2'b01, DIV);
      vectors++; if (fe_cnt - fe0 !== 1)  begin miscompares++; $display("FAIL stop_frame_err: got %0d, expected 1", fe_cnt - fe0); end
      vectors++; if (beat_cnt - b0 !== 0) begin miscompares++; $display("FAIL stop_no_push: got %0d, expected 0", beat_cnt - b0); end
      drive(2'b11, 2 * DIV);
      exp_q.push_back(8'h55);
      send_frame(8'h55, 2'b11, -1, -1, FRAME);
      drive(2'b11, 50);
      vectors++; if (beat_cnt - b0 !== 1) begin miscompares++; $display("FAIL after_err_beats: got %0d, expected 1", beat_cnt - b0); end
      vectors++; if (fe_cnt - fe0 !== 1)  begin miscompares++; $display("FAIL after_err_frame_err: got %0d, expected 1", fe_cnt - fe0); end
      vectors++; if (ov_cnt - ov0 !== 0)  begin miscompares++; $display("FAIL after_err_overflow: got %0d, expected 0", ov_cnt - ov0); end
   endtask

   task automatic test_carrier_loss();
      int fe0, b0;
      fe0 = fe_cnt; b0 = beat_cnt;
      o_tready = 1'b1;
      fork
         send_frame(8'h81, 2'b11, -1, 5, FRAME);
         begin
            repeat (502) @(posedge clk);
            @(negedge clk);
            vectors++; if (o_carrier !== 1'b1) begin miscompares++; $display("FAIL carrier_hold: got %b, expected 1", o_carrier); end
            @(negedge clk);
            vectors++; if (o_carrier !== 1'b0) begin miscompares++; $display("FAIL carrier_drop: got %b, expected 0", o_carrier); end
         end
      join
      drive(2'b11, 2 * DIV);
      vectors++; if (fe_cnt - fe0 !== 1)  begin miscompares++; $display("FAIL loss_frame_err: got %0d, expected 1", fe_cnt - fe0); end
      vectors++; if (beat_cnt - b0 !== 0) begin miscompares++; $display("FAIL loss_no_push: got %0d, expected 0", beat_cnt - b0); end
      exp_q.push_back(8'h81);
      send_frame(8'h81, 2'b11, -1, -1, FRAME);
      drive(2'b11, 50);
      vectors++; if (beat_cnt - b0 !== 1) begin miscompares++; $display("FAIL loss_recover_beats: got %0d, expected 1", beat_cnt - b0); end
      vectors++; if (exp_q.size() !== 0)  begin miscompares++; $display("FAIL loss_recover_left: got %0d, expected 0", exp_q.size()); end
   endtask

   task automatic test_glitch();
      int fe0, b0;
      fe0 = fe_cnt; b0 = beat_cnt;
      o_tready = 1'b1;
      drive(2'b01, 30);
      drive(2'b11, 200);
      vectors++; if (beat_cnt - b0 !== 0) begin miscompares++; $display("FAIL idle_glitch_beats: got %0d, expected 0", beat_cnt - b0); end
      vectors++; if (fe_cnt - fe0 !== 0)  begin miscompares++; $display("FAIL idle_glitch_err: got %0d, expected 0", fe_cnt - fe0); end
      exp_q.push_back(8'h00);
      // single 1 cycle lands inside the 3-sample window of data bit 2
      send_frame(8'h00, 2'b11, 349, -1, FRAME);
      drive(2'b11, 50);
      vectors++; if (beat_cnt - b0 !== 1) begin miscompares++; $display("FAIL majority_beats: got %0d, expected 1", beat_cnt - b0); end
      vectors++; if (fe_cnt - fe0 !== 0)  begin miscompares++; $display("FAIL majority_err: got %0d, expected 0", fe_cnt - fe0); end
   endtask

   task automatic test_reset_mid();
      int fe0, b0;
      o_tready = 1'b0;
      send_frame(8'h11, 2'b11, -1, -1, FRAME);
      send_frame(8'h22, 2'b11, -1, -1, FRAME);
      send_frame(8'h33, 2'b11, -1, -1, FRAME);
      send_frame(8'h44, 2'b11, -1, -1, 400);
      vectors++; if (o_tvalid !== 1'b1) begin miscompares++; $display("FAIL queued_tvalid: got %b, expected 1", o_tvalid); end
      vectors++; if (o_tdata !== 8'h11) begin miscompares++; $display("FAIL queued_head: got %02h, expected 11", o_tdata); end
      rst_n = 1'b0;
      #1;
      vectors++; if (o_tvalid !== 1'b0)  begin miscompares++; $display("FAIL async_tvalid: got %b, expected 0", o_tvalid); end
      vectors++; if (o_tdata !== 8'h00)  begin miscompares++; $display("FAIL async_tdata: got %02h, expected 00", o_tdata); end
      vectors++; if (o_carrier !== 1'b0) begin miscompares++; $display("FAIL async_carrier: got %b, expected 0", o_carrier); end
      vectors++; if (o_frame_err !== 1'b0 || o_overflow !== 1'b0) begin miscompares++; $display("FAIL async_pulses: got %b%b, expected 00", o_frame_err, o_overflow); end
      exp_q.delete();
      cyc(3);
      rst_n = 1'b1;
      fe0 = fe_cnt; b0 = beat_cnt;
      drive(2'b01, 200);
      vectors++; if (fe_cnt - fe0 !== 0 || o_tvalid !== 1'b0) begin miscompares++; $display("FAIL unarmed_start: err %0d valid %b, expected 0 0", fe_cnt - fe0, o_tvalid); end
      drive(2'b11, 50);
      o_tready = 1'b1;
      exp_q.push_back(8'hC3);
      send_frame(8'hC3, 2'b11, -1, -1, FRAME);
      drive(2'b11, 50);
      vectors++; if (beat_cnt - b0 !== 1) begin miscompares++; $display("FAIL post_reset_beats: got %0d, expected 1", beat_cnt - b0); end
      vectors++; if (exp_q.size() !== 0)  begin miscompares++; $display("FAIL post_reset_left: got %0d, expected 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_frame_err();
      test_carrier_loss();
      test_glitch();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/axis_ask_uart_rx.md
# axis_ask_uart_rx

ASK-line receiver: the decoding end of the 2-bit ASK symbol stream produced by the ASK UART transmitter. It samples the two comparator outputs of the analog front end, recovers 8N1 UART frames from the amplitude levels, and buffers the received bytes in a FIFO. Bytes leave on an AXI-Stream master port for the same byte-level fabric as the wire UART receiver. Status pulses report framing errors, overflow and carrier loss.

## Interface
- RX_SIZE, 4, FIFO address width; FIFO depth = 2**RX_SIZE bytes.
- clkdiv_rx, 100, clk cycles per UART bit; legal range ≥ 8.
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- ask_rx  in  2  comparator levels from the ASK front end; asynchronous to clk.
- o_tdata  out  8  received byte at the FIFO head.
- o_tvalid  out  1  FIFO non-empty.
- o_tready  in  1  downstream accept.
- o_frame_err  out  1  one-cycle pulse: stop bit 0, or carrier lost mid-frame.
- o_overflow  out  1  one-cycle pulse: a good byte was dropped because the FIFO was full.
- o_carrier  out  1  level: the synchronized symbol is a valid carrier level.

## Operation
- Input: ask_rx passes through a 2-flop synchronizer. Both stages reset to 2'b00.
- Symbol decode of the synchronized value:
  - 2'b11 = logic 1 (mark/idle).
  - 2'b01 = logic 0 (space).
  - 2'b00 and 2'b10 = no carrier.
- Sample history: a 3-deep shift register holds the decoded bit on every clk. At each sample point the bit value is the majority of the 3 entries.
- Arming: after reset, a framing error or a carrier loss, the receiver is disarmed. It arms on the first cycle whose decoded symbol is carrier + 1.
- FSM states: IDLE, START, DATA, STOP, WAIT1.
  - IDLE: when armed and the decoded symbol is carrier + 0 (cycle T0), clear the bit counter and go to START.
  - START: at T0+floor(clkdiv_rx/2), take the majority. If 0, go to DATA. If 1, treat it as a glitch and return to IDLE without reporting an error.
  - DATA: sample at each further clkdiv_rx. Shift in 8 bits, LSB first. After bit 7, go to STOP.
  - STOP, majority 1: push the byte and go to IDLE.
  - STOP, majority 0: pulse o_frame_err, discard the byte, disarm and go to WAIT1.
  - WAIT1: hold until a carrier + 1 symbol, then go to IDLE, armed.
- Carrier loss: a no-carrier symbol in START, DATA or STOP aborts the frame. The receiver pulses o_frame_err once, discards the byte, disarms and goes to IDLE. Carrier loss in IDLE or WAIT1 only disarms.
- o_carrier is the registered decode of the synchronizer output (carrier present).
- FIFO is first-word fall-through, depth 2**RX_SIZE. The count is RX_SIZE+1 bits wide and the pointers wrap modulo the depth.
  - A push is accepted if count < depth, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and o_overflow pulses.
  - A pop happens when o_tvalid & o_tready.
  - Simultaneous push and pop leaves the count unchanged.
- The bit timing counter is $clog2(clkdiv_rx) bits wide and reloads at every sample point.

## Timing
- Reset values:
  - o_tdata = 8'h00, o_tvalid = 0, o_frame_err = 0, o_overflow = 0, o_carrier = 0.
  - FSM in IDLE, disarmed; FIFO empty; counters 0.
- Pin-to-decode latency is 2 cycles (synchronizer). o_carrier follows 1 cycle later.
- Sample points, relative to T0:
  - start bit: floor(clkdiv_rx/2)
  - data bit k (0..7): floor(clkdiv_rx/2) + (k+1)·clkdiv_rx
  - stop bit: floor(clkdiv_rx/2) + 9·clkdiv_rx (sample cycle S)
- Push happens at S+1. o_tvalid rises at S+1 when the FIFO was empty.
- o_frame_err and o_overflow are asserted for exactly the single cycle S+1.
- o_tdata and o_tvalid are stable while o_tvalid & ~o_tready.
- rst_n low mid-frame: everything is cleared immediately (asynchronous). Partial bytes and FIFO contents are lost. After release, a 1 symbol is needed to re-arm.
- Back-to-back frames: a start edge is accepted on the first 0 after returning to IDLE. There is no minimum idle time beyond the stop bit.

## Test plan
- Drive 0xA5 as 8N1 (clkdiv_rx=100; 11 = 1, 01 = 0), o_tready=1 → o_tvalid rises at stop sample+1 with o_tdata=0xA5; one beat; no error pulses.
- Drive 20 back-to-back bytes 0x00..0x13 with o_tready=0 (RX_SIZE=4) → 16 bytes held, 4 o_overflow pulses; then o_tready=1 drains exactly 0x00..0x0F in order.
- Drive 0x3C with stop bit forced 01 → one o_frame_err pulse, no push. A following start is ignored until a 11 symbol is seen; the next good 0x55 is received.
- Drive 2'b00 during data bit 4 → o_frame_err pulse, o_carrier falls 3 cycles after the pin changes, no push; after 11 returns, 0x81 is received correctly.
- Drive a 0 glitch of 30 cycles in idle → no o_tvalid, no error pulse. Drive a single-cycle 1 glitch at the data-bit-2 sample point of 0x00 → 0x00 is received (majority vote).
- Assert rst_n low mid-frame with 3 bytes queued → all outputs 0 immediately, FIFO empty; after release and an 11 symbol, 0xC3 is received.
